fltadd_seq: RTL and testbench

- Sequencer that feeds the float-add datapath from data memory: fetches operand pairs over the 8-bit data_mem port, hands each pair to the adder through a start/done handshake, and writes each sum back to memory.
- Supports a batch of N consecutive operand records, so one program `start` processes an array.
- Sits between the top-level start/done pins, data_mem, and the float adder core.

---
 rtl/fltadd_pkg.sv | 11 +
 rtl/fltadd_rec_addr.sv | 32 +++
 rtl/fltadd_seq.sv | 95 +++++++++
 tb/tb_fltadd_seq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fltadd_pkg.sv
// fltadd_pkg: sequencer states, half-precision field positions and record byte offsets.
package fltadd_pkg;
  typedef enum logic [3:0] {IDLE, RD0, RD1, RD2, RD3, CAP, GO, WAIT, WR0, WR1, NEXT, DONE} state_t;
  localparam int SIGN_BIT = 15;
  localparam int EXP_HI = 14;
  localparam int EXP_LO = 10;
  localparam int MANT_HI = 9;
  localparam logic [2:0] OFF_A = 3'd0;
  localparam logic [2:0] OFF_B = 3'd2;
  localparam logic [2:0] OFF_S = 3'd4;
endpackage

// File: rtl/fltadd_rec_addr.sv
// fltadd_rec_addr: record pointer and remaining-count tracker; byte address wraps mod 256.
module fltadd_rec_addr #(
  parameter int CW = 4,
  parameter logic [7:0] BASE = 8'd8,
  parameter logic [7:0] STRIDE = 8'd6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic          i_step,
  input  logic [CW-1:0] i_count,
  input  logic [2:0]    i_off,
  output logic [7:0]    o_addr,
  output logic          o_last
);
  logic [7:0] r_ptr;
  logic [CW-1:0] r_rem;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= 8'd0;
      r_rem <= '0;
    end else if (i_load) begin
      r_ptr <= BASE;
      r_rem <= i_count;
    end else if (i_step) begin
      r_ptr <= r_ptr + STRIDE;
      r_rem <= r_rem - CW'(1);
    end
  end
  assign o_addr = r_ptr + {5'd0, i_off};
  assign o_last = r_rem == CW'(1);
endmodule

// File: rtl/fltadd_seq.sv
// fltadd_seq: fetches operand pairs from data memory, runs them through the float adder, writes sums back.
module fltadd_seq
  import fltadd_pkg::*;
#(
  parameter int BASE_ADDR = 8,
  parameter int REC_STRIDE = 6,
  parameter int MAX_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [MAX_CNT_W-1:0] count,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           DataAddress,
  output logic                 ReadMem,
  output logic                 WriteMem,
  output logic [7:0]           DataIn,
  input  logic [7:0]           DataOut,
  output logic                 add_start,
  output logic [15:0]          add_a,
  output logic [15:0]          add_b,
  input  logic                 add_done,
  input  logic [15:0]          add_sum
);
  state_t r_state, w_next;
  logic w_load, w_step, w_last, w_wr;
  logic [2:0] w_off;
  logic [7:0] w_addr;
  logic [15:0] r_sum;
  fltadd_rec_addr #(
    .CW(MAX_CNT_W),
    .BASE(8'(BASE_ADDR)),
    .STRIDE(8'(REC_STRIDE))
  ) u_rec (
    .clk(clk),
    .reset(reset),
    .i_load(w_load),
    .i_step(w_step),
    .i_count(count),
    .i_off(w_off),
    .o_addr(w_addr),
    .o_last(w_last)
  );
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  // Read data trails ReadMem by one cycle, so each byte lands in the state after its read.
  always_ff @(posedge clk) begin
    if (reset) begin
      add_a <= 16'd0;
      add_b <= 16'd0;
      r_sum <= 16'd0;
    end else begin
      if (r_state == RD1) add_a[7:0] <= DataOut;
      if (r_state == RD2) add_a[15:8] <= DataOut;
      if (r_state == RD3) add_b[7:0] <= DataOut;
      if (r_state == CAP) add_b[15:8] <= DataOut;
      if (r_state == WAIT && add_done) r_sum <= add_sum;
    end
  end
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    w_off = OFF_A;
    w_wr = 1'b0;
    ReadMem = 1'b0;
    add_start = 1'b0;
    unique case (r_state)
      IDLE, DONE: if (start) begin
        w_load = 1'b1;
        w_next = (count == '0) ? DONE : RD0;
      end
      RD0: begin ReadMem = 1'b1; w_off = OFF_A; w_next = RD1; end
      RD1: begin ReadMem = 1'b1; w_off = OFF_A + 3'd1; w_next = RD2; end
      RD2: begin ReadMem = 1'b1; w_off = OFF_B; w_next = RD3; end
      RD3: begin ReadMem = 1'b1; w_off = OFF_B + 3'd1; w_next = CAP; end
      CAP: w_next = GO;
      GO: begin add_start = 1'b1; w_next = WAIT; end
      WAIT: w_next = add_done ? WR0 : WAIT;
      WR0: begin w_wr = 1'b1; w_off = OFF_S; w_next = WR1; end
      WR1: begin w_wr = 1'b1; w_off = OFF_S + 3'd1; w_next = NEXT; end
      NEXT: begin w_step = 1'b1; w_next = w_last ? DONE : RD0; end
      default: w_next = IDLE;
    endcase
  end
  // Suppress the strobe in the reset cycle so an interrupted record never half-writes.
  assign WriteMem = w_wr && !reset;
  assign DataAddress = (ReadMem || w_wr) ? w_addr : 8'd0;
  assign DataIn = (r_state == WR0) ? r_sum[7:0] : (r_state == WR1) ? r_sum[15:8] : 8'd0;
  assign busy = r_state != IDLE && r_state != DONE;
  assign done = r_state == DONE;
endmodule

// File: tb/tb_fltadd_seq.sv
// tb_fltadd_seq: scoreboard bench; two sequencers (base 8 and base 0xFC) each with a memory and adder stub.
module tb_fltadd_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset[2], start[2], busy[2], done[2], rd[2], wr[2], add_start[2];
  logic [3:0] count[2];
  logic [7:0] addr[2], din[2], dout[2];
  logic [15:0] add_a[2], add_b[2];
  logic [7:0] mem[2][256];
  int lat[2], wr_cnt[2], rd_cnt[2], st_cnt[2];
  int checks = 0, errors = 0;
  typedef struct {int u; logic [7:0] a; logic [7:0] d;} wr_t;
  wr_t exp_q[$];
  logic [7:0] rd_log[$];
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic l_done;
    logic [15:0] l_sum, ha, hb;
    int r;
    wr_t e;
    fltadd_seq #(.BASE_ADDR(g ? 252 : 8)) u_dut (
      .clk(clk), .reset(reset[g]), .start(start[g]), .count(count[g]),
      .busy(busy[g]), .done(done[g]), .DataAddress(addr[g]), .ReadMem(rd[g]),
      .WriteMem(wr[g]), .DataIn(din[g]), .DataOut(dout[g]), .add_start(add_start[g]),
      .add_a(add_a[g]), .add_b(add_b[g]), .add_done(l_done), .add_sum(l_sum)
    );
    always @(posedge clk) begin
      if (rd[g]) dout[g] <= mem[g][addr[g]];
      if (wr[g]) mem[g][addr[g]] <= din[g];
    end
    // Adder stub: doubles operand A (bumps the exponent), valid for equal normal operands.
    always @(posedge clk) begin
      if (reset[g]) r <= 0;
      else if (add_start[g]) begin r <= lat[g]; ha <= add_a[g]; hb <= add_b[g]; end
      else if (r > 0) r <= r - 1;
    end
    assign l_done = r == 1;
    assign l_sum = ha + 16'h0400;
    always @(negedge clk) begin
      if (rd[g] && wr[g]) begin errors++; $display("FAIL rd_wr_overlap inst=%0d addr=%0h", g, addr[g]); end
      if (rd[g]) begin rd_cnt[g]++; rd_log.push_back(addr[g]); end
      if (add_start[g]) st_cnt[g]++;
      if (l_done) begin
        checks++;
        if ({add_a[g], add_b[g]} !== {ha, hb}) begin
          errors++; $display("FAIL operand_hold inst=%0d got %0h/%0h want %0h/%0h", g, add_a[g], add_b[g], ha, hb);
        end
      end
      if (wr[g]) begin
        wr_cnt[g]++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL unexpected_write inst=%0d addr=%0h data=%0h", g, addr[g], din[g]);
        end else begin
          e = exp_q.pop_front();
          if (e.u != g || addr[g] !== e.a || din[g] !== e.d) begin
            errors++; $display("FAIL write inst=%0d got %0h:%0h want inst %0d %0h:%0h", g, addr[g], din[g], e.u, e.a, e.d);
          end
        end
      end
    end
  end
  task automatic clr(input int u);
    wr_cnt[u] = 0; rd_cnt[u] = 0; st_cnt[u] = 0; rd_log.delete();
  endtask
  task automatic put_rec(input int u, input logic [7:0] base, input logic [15:0] a, input logic [15:0] b);
    mem[u][base] = a[7:0]; mem[u][8'(base + 8'd1)] = a[15:8];
    mem[u][8'(base + 8'd2)] = b[7:0]; mem[u][8'(base + 8'd3)] = b[15:8];
    mem[u][8'(base + 8'd4)] = 8'hAA; mem[u][8'(base + 8'd5)] = 8'h55;
  endtask
  task automatic expect_sum(input int u, input logic [7:0] sa, input logic [15:0] s);
    exp_q.push_back('{u, sa, s[7:0]});
    exp_q.push_back('{u, 8'(sa + 8'd1), s[15:8]});
  endtask
  task automatic run(input int u, input logic [3:0] n, input int poke, output int bc, output bit ok);
    @(posedge clk); #1 count[u] = n; start[u] = 1'b1;
    @(posedge clk); #1 start[u] = 1'b0; count[u] = 4'd0;
    bc = 0; ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done[u]) begin ok = 1'b1; break; end
      if (busy[u]) bc++;
      start[u] = bc == poke;
      count[u] = start[u] ? 4'd5 : 4'd0;
      @(posedge clk); #1;
    end
    start[u] = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL done_timeout inst=%0d count=%0d", u, n); end
  endtask
  task automatic test_reset;
    reset[0] = 1'b1; reset[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset[0] = 1'b0; reset[1] = 1'b0;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({busy[u], done[u], rd[u], wr[u], add_start[u], addr[u], din[u], add_a[u], add_b[u]} !== 53'd0) begin
        errors++; $display("FAIL reset_outputs inst=%0d busy=%b done=%b rd=%b wr=%b st=%b addr=%0h din=%0h a=%0h b=%0h want all 0",
          u, busy[u], done[u], rd[u], wr[u], add_start[u], addr[u], din[u], add_a[u], add_b[u]);
      end
    end
  endtask
  task automatic test_single;
    int bc; bit ok;
    clr(0); lat[0] = 1;
    put_rec(0, 8'd8, 16'h3C00, 16'h3C00);
    expect_sum(0, 8'd12, 16'h4000);
    run(0, 4'd1, -1, bc, ok);
    checks++;
    if (bc != 10) begin errors++; $display("FAIL single_latency got %0d want 10", bc); end
    checks++;
    if ({mem[0][12], mem[0][13]} !== 16'h0040) begin errors++; $display("FAIL single_mem got %0h%0h want 0040", mem[0][12], mem[0][13]); end
    checks++;
    if (!done[0] || busy[0]) begin errors++; $display("FAIL single_done done=%b busy=%b want 1 0", done[0], busy[0]); end
  endtask
  task automatic test_batch;
    int bc; bit ok;
    clr(0); lat[0] = 1;
    put_rec(0, 8'd8, 16'h3E00, 16'h3E00);
    put_rec(0, 8'd14, 16'h3C00, 16'h3C00);
    put_rec(0, 8'd20, 16'h4000, 16'h4000);
    expect_sum(0, 8'd12, 16'h4200);
    expect_sum(0, 8'd18, 16'h4000);
    expect_sum(0, 8'd24, 16'h4400);
    run(0, 4'd3, -1, bc, ok);
    checks++;
    if (wr_cnt[0] != 6) begin errors++; $display("FAIL batch_writes got %0d want 6", wr_cnt[0]); end
    checks++;
    if (bc != 30) begin errors++; $display("FAIL batch_latency got %0d want 30", bc); end
    checks++;
    if ({mem[0][12], mem[0][13], mem[0][18], mem[0][19], mem[0][24], mem[0][25]} !== 48'h004200400044) begin
      errors++; $display("FAIL batch_mem got %0h %0h %0h want 4200 4000 4400",
        {mem[0][13], mem[0][12]}, {mem[0][19], mem[0][18]}, {mem[0][25], mem[0][24]});
    end
  endtask
  task automatic test_zero;
    int bc; bit ok;
    clr(0);
    run(0, 4'd0, -1, bc, ok);
    checks++;
    if (bc != 0) begin errors++; $display("FAIL zero_busy got %0d want 0", bc); end
    repeat (3) @(posedge clk);
    #1 checks++;
    if (rd_cnt[0] + wr_cnt[0] + st_cnt[0] != 0 || !done[0]) begin
      errors++; $display("FAIL zero_idle rd=%0d wr=%0d st=%0d done=%b want 0 0 0 1", rd_cnt[0], wr_cnt[0], st_cnt[0], done[0]);
    end
  endtask
  task automatic test_slow;
    int bc; bit ok;
    clr(0); lat[0] = 7;
    put_rec(0, 8'd8, 16'h3C00, 16'h3C00);
    expect_sum(0, 8'd12, 16'h4000);
    run(0, 4'd1, 8, bc, ok);
    checks++;
    if (bc != 16) begin errors++; $display("FAIL slow_latency got %0d want 16", bc); end
    checks++;
    if (st_cnt[0] != 1 || wr_cnt[0] != 2 || rd_cnt[0] != 4) begin
      errors++; $display("FAIL slow_restart st=%0d wr=%0d rd=%0d want 1 2 4", st_cnt[0], wr_cnt[0], rd_cnt[0]);
    end
    lat[0] = 1;
  endtask
  task automatic test_reset_mid;
    int bc; bit ok;
    bit seen = 1'b0;
    clr(0);
    put_rec(0, 8'd8, 16'h3C00, 16'h3C00);
    put_rec(0, 8'd14, 16'h3C00, 16'h3C00);
    @(posedge clk); #1 count[0] = 4'd2; start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (wr[0]) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL reset_mid_reach_wr0 got none want write strobe"); end
    reset[0] = 1'b1;
    @(posedge clk); #1 reset[0] = 1'b0;
    checks++;
    if ({busy[0], done[0], rd[0], wr[0], add_start[0], addr[0], din[0], add_a[0], add_b[0]} !== 53'd0) begin
      errors++; $display("FAIL reset_mid_outputs busy=%b done=%b rd=%b wr=%b addr=%0h a=%0h want all 0",
        busy[0], done[0], rd[0], wr[0], addr[0], add_a[0]);
    end
    checks++;
    if ({mem[0][12], mem[0][13]} !== 16'hAA55 || wr_cnt[0] != 0) begin
      errors++; $display("FAIL reset_mid_mem got %0h %0h writes=%0d want aa 55 0", mem[0][12], mem[0][13], wr_cnt[0]);
    end
    expect_sum(0, 8'd12, 16'h4000);
    run(0, 4'd1, -1, bc, ok);
    checks++;
    if (bc != 10 || {mem[0][12], mem[0][13]} !== 16'h0040) begin
      errors++; $display("FAIL reset_mid_rerun latency=%0d mem=%0h%0h want 10 0040", bc, mem[0][12], mem[0][13]);
    end
  endtask
  task automatic test_wrap;
    int bc; bit ok;
    clr(1); lat[1] = 1;
    put_rec(1, 8'hFC, 16'h3C00, 16'h3C00);
    expect_sum(1, 8'h00, 16'h4000);
    run(1, 4'd1, -1, bc, ok);
    checks++;
    if (rd_log.size() != 4 || {rd_log[0], rd_log[1], rd_log[2], rd_log[3]} !== 32'hFCFDFEFF) begin
      errors++; $display("FAIL wrap_reads count=%0d want FC FD FE FF", rd_log.size());
    end
    checks++;
    if ({mem[1][0], mem[1][1]} !== 16'h0040) begin errors++; $display("FAIL wrap_mem got %0h%0h want 0040", mem[1][0], mem[1][1]); end
  endtask
  initial begin
    for (int u = 0; u < 2; u++) begin
      reset[u] = 1'b1; start[u] = 1'b0; count[u] = 4'd0; lat[u] = 1;
      for (int a = 0; a < 256; a++) mem[u][a] = 8'h00;
    end
    test_reset;
    test_single;
    test_batch;
    test_zero;
    test_slow;
    test_reset_mid;
    test_wrap;
    repeat (2) @(posedge clk);
    #1 checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL pending_writes got %0d want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
